cpu_clock: RTL and testbench
============================

CPU_CLOCK -- requirements
Module: cpu_clock

Interface
REQ-001 Parameter COUNT_DIV, default 2, meaning: number of clk cycles per Count increment (legal range 1..16).
REQ-002 Parameter LFSR_SEED, default 16'hACE1, meaning: stall-pattern LFSR reset value (must be nonzero).
REQ-003 Port clk, input, 1, meaning: sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, meaning: reset; asynchronous, active-high.
REQ-005 Port rst_sync, output, 1, meaning: core reset; asserts asynchronously, releases synchronously.
REQ-006 Port cycle, output, 64, meaning: free-running cycle counter.
REQ-007 Port count_we, input, 1, meaning: Count write strobe.
REQ-008 Port count_wdata, input, 32, meaning: Count write data.
REQ-009 Port compare_we, input, 1, meaning: Compare write strobe.
REQ-010 Port compare_wdata, input, 32, meaning: Compare write data.
REQ-011 Port count, output, 32, meaning: CP0 Count value.
REQ-012 Port compare, output, 32, meaning: CP0 Compare value.
REQ-013 Port timer_int, output, 1, meaning: timer interrupt request, level.
REQ-014 Port fake_stall_en, input, 1, meaning: enables pseudo-random bus-stall injection.
REQ-015 Port stall, output, 1, meaning: injected stall for bus models.

Function
REQ-016 rst_sync SHALL be a 2-flop synchronizer: set to 1 immediately on rst; cleared on the 2nd rising clk edge after rst falls.
REQ-017 All other state SHALL be held at reset values while rst_sync is 1.
REQ-018 cycle SHALL increment by 1 every clk while rst_sync is 0; it wraps 2^64-1 -> 0.
REQ-019 A prescaler SHALL count 0..COUNT_DIV-1; count increments by 1 when the prescaler is at COUNT_DIV-1; count wraps FFFF_FFFF -> 0.
REQ-020 count_we SHALL load count_wdata next cycle and clear the prescaler; the write overrides any same-cycle increment.
REQ-021 compare_we SHALL load compare_wdata next cycle and clear timer_int next cycle.
REQ-022 timer_int SHALL set on the edge after a cycle where registered count == compare, and hold until a compare write.
REQ-023 Simultaneous compare_we and match: the clear wins; timer_int is 0 next cycle.
REQ-024 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, advancing every clk outside reset.
REQ-025 stall SHALL equal fake_stall_en & lfsr[0] & lfsr[1], registered, and forced 0 after 3 consecutive stall cycles, for one cycle.
REQ-026 Outputs count, compare, cycle and timer_int SHALL be driven directly from registers.

Reset
REQ-027 Reset values: rst_sync=1, cycle=0, count=0, prescaler=0, compare=FFFF_FFFF, timer_int=0, lfsr=LFSR_SEED, stall=0.
REQ-028 Reset mid-operation SHALL abort all counting immediately with no pending write retained.

Configuration
REQ-029 Macro CPU_CLOCK_STALL_INJECT_EN: when defined, the LFSR and stall logic are present per REQ-024/025.
REQ-030 When CPU_CLOCK_STALL_INJECT_EN is undefined, stall SHALL be constant 0, the LFSR is absent, and fake_stall_en is ignored.

Verification
REQ-031 Reset release: rst 1 -> 0 -> rst_sync falls on the 2nd edge; cycle = 5 after 5 further edges.
REQ-032 COUNT_DIV=2: 10 cycles after release -> count = 5; count_we with 32'h0000_0100 -> count = 0x100, then 0x101 two cycles later.
REQ-033 compare_we 0x10, count from 0 -> timer_int rises one cycle after count = 0x10 and stays high; compare_we 0x20 -> timer_int = 0 next cycle.
REQ-034 Write count = FFFF_FFFF -> count = 0 after COUNT_DIV cycles; with compare = 0, timer_int sets on the following edge.
REQ-035 CPU_CLOCK_STALL_INJECT_EN defined, fake_stall_en = 1 -> stall is never high more than 3 consecutive cycles over 10000 cycles; fake_stall_en = 0 -> stall = 0.
REQ-036 Same-cycle compare_we and match -> timer_int stays 0.

Source files
------------

// File: rtl/cpu_clock.sv
// CP0-style Count/Compare timer with a 64-bit cycle counter, reset synchronizer and optional
// pseudo-random bus-stall injector (enabled by defining CPU_CLOCK_STALL_INJECT_EN).
module cpu_clock #(
    parameter int unsigned COUNT_DIV = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rst_sync,
    output logic [63:0] cycle,
    input  logic        count_we,
    input  logic [31:0] count_wdata,
    input  logic        compare_we,
    input  logic [31:0] compare_wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int,
    input  logic        fake_stall_en,
    output logic        stall
);

    localparam logic [4:0] PRE_MAX = 5'(COUNT_DIV - 1);

    logic        sync_meta_r;
    logic        rst_sync_r;
    logic [63:0] cycle_r;
    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic [4:0]  prescale_r;
    logic        timer_int_r;

    logic [31:0] count_nxt_s;
    logic [4:0]  prescale_nxt_s;
    logic        timer_nxt_s;

    // Reset synchronizer: asserts with rst, releases on the second clean edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_r <= 1'b1;
            rst_sync_r  <= 1'b1;
        end else begin
            sync_meta_r <= 1'b0;
            rst_sync_r  <= sync_meta_r;
        end
    end

    // Next Count/prescaler: a software write beats the prescaled increment.
    always_comb begin
        count_nxt_s    = count_r;
        prescale_nxt_s = prescale_r;
        if (count_we) begin
            count_nxt_s    = count_wdata;
            prescale_nxt_s = 5'd0;
        end else if (prescale_r == PRE_MAX) begin
            count_nxt_s    = count_r + 32'd1;
            prescale_nxt_s = 5'd0;
        end else begin
            count_nxt_s    = count_r;
            prescale_nxt_s = prescale_r + 5'd1;
        end
    end

    // Next timer interrupt: a Compare write clears it even on a coincident match.
    always_comb begin
        timer_nxt_s = timer_int_r;
        if (compare_we) begin
            timer_nxt_s = 1'b0;
        end else if (count_r == compare_r) begin
            timer_nxt_s = 1'b1;
        end else begin
            timer_nxt_s = timer_int_r;
        end
    end

    // Counter and timer state, held in reset until the synchronized reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_r     <= 64'd0;
            count_r     <= 32'd0;
            prescale_r  <= 5'd0;
            compare_r   <= 32'hFFFF_FFFF;
            timer_int_r <= 1'b0;
        end else if (rst_sync_r) begin
            cycle_r     <= 64'd0;
            count_r     <= 32'd0;
            prescale_r  <= 5'd0;
            compare_r   <= 32'hFFFF_FFFF;
            timer_int_r <= 1'b0;
        end else begin
            cycle_r     <= cycle_r + 64'd1;
            count_r     <= count_nxt_s;
            prescale_r  <= prescale_nxt_s;
            compare_r   <= compare_we ? compare_wdata : compare_r;
            timer_int_r <= timer_nxt_s;
        end
    end

    assign rst_sync  = rst_sync_r;
    assign cycle     = cycle_r;
    assign count     = count_r;
    assign compare   = compare_r;
    assign timer_int = timer_int_r;

`ifdef CPU_CLOCK_STALL_INJECT_EN
    logic [15:0] lfsr_r;
    logic [1:0]  run_r;
    logic        stall_r;
    logic        lfsr_fb_s;
    logic        stall_nxt_s;

    // Stall request from the LFSR, suppressed for one cycle after a run of three.
    always_comb begin
        lfsr_fb_s   = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
        stall_nxt_s = 1'b0;
        if (run_r == 2'd3) begin
            stall_nxt_s = 1'b0;
        end else begin
            stall_nxt_s = fake_stall_en & lfsr_r[0] & lfsr_r[1];
        end
    end

    // LFSR, stall register and consecutive-stall run counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r  <= LFSR_SEED;
            run_r   <= 2'd0;
            stall_r <= 1'b0;
        end else if (rst_sync_r) begin
            lfsr_r  <= LFSR_SEED;
            run_r   <= 2'd0;
            stall_r <= 1'b0;
        end else begin
            lfsr_r  <= {lfsr_r[14:0], lfsr_fb_s};
            run_r   <= stall_nxt_s ? (run_r + 2'd1) : 2'd0;
            stall_r <= stall_nxt_s;
        end
    end

    assign stall = stall_r;
`else
    logic unused_stall_en_s;

    assign unused_stall_en_s = fake_stall_en;
    assign stall             = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_clock.sv
// Directed self-checking bench for cpu_clock (COUNT_DIV=2): reset release, Count/Compare,
// timer interrupt set/clear priority, wrap, mid-operation reset and stall injection.
module tb_cpu_clock;

    logic        clk;
    logic        rst;
    logic        rst_sync;
    logic [63:0] cycle;
    logic        count_we;
    logic [31:0] count_wdata;
    logic        compare_we;
    logic [31:0] compare_wdata;
    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_int;
    logic        fake_stall_en;
    logic        stall;

    int total;
    int bad;

    cpu_clock #(.COUNT_DIV(2), .LFSR_SEED(16'hACE1)) dut (
        .clk           (clk),
        .rst           (rst),
        .rst_sync      (rst_sync),
        .cycle         (cycle),
        .count_we      (count_we),
        .count_wdata   (count_wdata),
        .compare_we    (compare_we),
        .compare_wdata (compare_wdata),
        .count         (count),
        .compare       (compare),
        .timer_int     (timer_int),
        .fake_stall_en (fake_stall_en),
        .stall         (stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef CPU_CLOCK_STALL_INJECT_EN
    int run_len;
    int max_run;
    int highs;
`endif

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        count_we      = 1'b0;
        count_wdata   = 32'd0;
        compare_we    = 1'b0;
        compare_wdata = 32'd0;
        fake_stall_en = 1'b0;

        repeat (3) tick();
        chk("rst_rst_sync", 64'(rst_sync), 64'd1);
        chk("rst_cycle", cycle, 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_compare", 64'(compare), 64'hFFFF_FFFF);
        chk("rst_timer", 64'(timer_int), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);

        // Release: rst_sync drops on the second edge, then cycle counts.
        rst = 1'b0;
        tick();
        chk("rel_edge1_rst_sync", 64'(rst_sync), 64'd1);
        tick();
        chk("rel_edge2_rst_sync", 64'(rst_sync), 64'd0);
        chk("rel_edge2_cycle", cycle, 64'd0);
        repeat (5) tick();
        chk("cycle_5", cycle, 64'd5);
        chk("count_after5", 64'(count), 64'd2);
        repeat (5) tick();
        chk("cycle_10", cycle, 64'd10);
        chk("count_after10", 64'(count), 64'd5);

        // Count write clears the prescaler.
        count_we    = 1'b1;
        count_wdata = 32'h0000_0100;
        tick();
        count_we = 1'b0;
        chk("cnt_wr_0", 64'(count), 64'h100);
        tick();
        chk("cnt_wr_1", 64'(count), 64'h100);
        tick();
        chk("cnt_wr_2", 64'(count), 64'h101);

        // Compare match from count 0.
        count_we      = 1'b1;
        count_wdata   = 32'd0;
        compare_we    = 1'b1;
        compare_wdata = 32'h10;
        tick();
        count_we   = 1'b0;
        compare_we = 1'b0;
        chk("cmp_loaded", 64'(compare), 64'h10);
        chk("cmp_timer_clr", 64'(timer_int), 64'd0);
        repeat (32) tick();
        chk("cmp_count_10", 64'(count), 64'h10);
        chk("cmp_timer_not_yet", 64'(timer_int), 64'd0);
        tick();
        chk("cmp_timer_set", 64'(timer_int), 64'd1);
        repeat (10) tick();
        chk("cmp_timer_hold", 64'(timer_int), 64'd1);
        compare_we    = 1'b1;
        compare_wdata = 32'h20;
        tick();
        compare_we = 1'b0;
        chk("cmp_wr_clears", 64'(timer_int), 64'd0);
        chk("cmp_wr_value", 64'(compare), 64'h20);

        // Count wrap with Compare = 0.
        count_we      = 1'b1;
        count_wdata   = 32'hFFFF_FFFF;
        compare_we    = 1'b1;
        compare_wdata = 32'd0;
        tick();
        count_we   = 1'b0;
        compare_we = 1'b0;
        chk("wrap_cnt_max", 64'(count), 64'hFFFF_FFFF);
        tick();
        chk("wrap_timer_pre", 64'(timer_int), 64'd0);
        tick();
        chk("wrap_cnt_zero", 64'(count), 64'd0);
        chk("wrap_timer_match_cycle", 64'(timer_int), 64'd0);
        tick();
        chk("wrap_timer_set", 64'(timer_int), 64'd1);

        // Compare write during a live match (count 0 == compare 0): clear wins.
        compare_we    = 1'b1;
        compare_wdata = 32'h50;
        tick();
        compare_we = 1'b0;
        chk("prio1_timer", 64'(timer_int), 64'd0);
        chk("prio1_compare", 64'(compare), 64'h50);
        count_we    = 1'b1;
        count_wdata = 32'h50;
        tick();
        count_we = 1'b0;
        chk("prio2_count", 64'(count), 64'h50);
        chk("prio2_timer_before", 64'(timer_int), 64'd0);
        compare_we    = 1'b1;
        compare_wdata = 32'h60;
        tick();
        compare_we = 1'b0;
        chk("prio2_timer_clear_wins", 64'(timer_int), 64'd0);
        tick();
        chk("prio2_timer_stays", 64'(timer_int), 64'd0);

`ifdef CPU_CLOCK_STALL_INJECT_EN
        fake_stall_en = 1'b1;
        run_len       = 0;
        max_run       = 0;
        highs         = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (stall === 1'b1) begin
                run_len++;
                highs++;
            end else begin
                run_len = 0;
            end
            if (run_len > max_run) max_run = run_len;
        end
        chk("stall_max_run_le3", 64'(max_run <= 3), 64'd1);
        chk("stall_seen_high", 64'(highs > 0), 64'd1);
        fake_stall_en = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("stall_off", 64'(stall), 64'd0);
            tick();
        end
`else
        fake_stall_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("stall_absent", 64'(stall), 64'd0);
        end
        fake_stall_en = 1'b0;
`endif

        // Mid-operation reset takes effect without a clock edge; pending write is dropped.
        #2;
        rst         = 1'b1;
        count_we    = 1'b1;
        count_wdata = 32'h1234;
        #1;
        chk("async_rst_sync", 64'(rst_sync), 64'd1);
        chk("async_count", 64'(count), 64'd0);
        chk("async_cycle", cycle, 64'd0);
        chk("async_compare", 64'(compare), 64'hFFFF_FFFF);
        tick();
        count_we = 1'b0;
        chk("rst_write_dropped", 64'(count), 64'd0);
        rst = 1'b0;
        repeat (2) tick();
        chk("rerelease_rst_sync", 64'(rst_sync), 64'd0);
        repeat (4) tick();
        chk("rerelease_count", 64'(count), 64'd2);
        chk("rerelease_cycle", cycle, 64'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
